// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, FSM state encoding
// and the multiply/divide sub-operation encoding.
package ex_pkg;

    localparam int DEF_DATA_W = 32;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_NOR   = 5'd5;
    localparam logic [4:0] ALU_SLT   = 5'd6;
    localparam logic [4:0] ALU_SLTU  = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MFHI  = 5'd20;
    localparam logic [4:0] ALU_MFLO  = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

    // Low two bits of the md op codes 16..19 map directly onto this encoding.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    function automatic logic is_md_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ex_stage_mul_div.sv
// Iterative radix-2 multiply/divide on operand magnitudes with sign fix-up at
// the output; shift-add multiply and restoring divide share one 2W register.
module mul_div_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  md_op_e            op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] dvd_q;
    logic              is_div_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic              dbz_q;

    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;

    function automatic logic [DATA_W-1:0] sign_fix_w(input logic neg, input logic [DATA_W-1:0] x);
        return neg ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] sign_fix_dw(input logic neg, input logic [2*DATA_W-1:0] x);
        return neg ? -x : x;
    endfunction

    assign signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    assign a_neg     = signed_op && a_i[DATA_W-1];
    assign b_neg     = signed_op && b_i[DATA_W-1];
    assign mag_a     = sign_fix_w(a_neg, a_i);
    assign mag_b     = sign_fix_w(b_neg, b_i);

    // One iteration: add-and-shift-right for multiply, shift-left-and-trial-subtract for divide.
    always_comb begin
        logic [DATA_W:0] sum;
        logic [DATA_W:0] trial;
        sum      = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mcand_q};
        trial    = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, mcand_q};
        acc_step = acc_q;
        if (is_div_q) begin
            if (!trial[DATA_W]) begin
                acc_step = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = {acc_q[2*DATA_W-2:0], 1'b0};
            end
        end else if (acc_q[0]) begin
            acc_step = {sum, acc_q[DATA_W-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*DATA_W-1:1]};
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
        end else if (busy_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            acc_q    <= {{DATA_W{1'b0}}, mag_a};
            mcand_q  <= mag_b;
            dvd_q    <= a_i;
            is_div_q <= (op_i == MD_DIV) || (op_i == MD_DIVU);
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            dbz_q    <= (b_i == '0);
        end else if (busy_q) begin
            acc_q <= acc_step;
        end
    end

    // Most-negative / -1 needs no special case: magnitude 2^(W-1) negates to itself.
    always_comb begin
        logic [2*DATA_W-1:0] prod;
        prod = sign_fix_dw(neg_q_q, acc_q);
        if (!is_div_q) begin
            hi_o = prod[2*DATA_W-1:DATA_W];
            lo_o = prod[DATA_W-1:0];
        end else if (dbz_q) begin
            hi_o = dvd_q;
            lo_o = '1;
        end else begin
            hi_o = sign_fix_w(neg_r_q, acc_q[2*DATA_W-1:DATA_W]);
            lo_o = sign_fix_w(neg_q_q, acc_q[DATA_W-1:0]);
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus iterative multiply/divide into HI/LO,
// registered into the EX/MEM boundary, with a stall back to the hazard unit.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RD_W    = 5,
    parameter int CTRL_W  = 32,
    parameter int ALUOP_W = 5
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  data_1,
    input  logic [DATA_W-1:0]  data_2,
    input  logic [RD_W-1:0]    RD,
    input  logic [CTRL_W-1:0]  Control,
    input  logic [ALUOP_W-1:0] ALU_Control,
    output logic               stall,
    output logic               out_valid,
    output logic [DATA_W-1:0]  ALU_result,
    output logic [DATA_W-1:0]  store_data,
    output logic [RD_W-1:0]    RD_out,
    output logic [CTRL_W-1:0]  Control_out,
    output logic [DATA_W-1:0]  HI,
    output logic [DATA_W-1:0]  LO
);

    localparam int SH_W = $clog2(DATA_W);

    ex_state_e         state_q, state_d;
    logic [4:0]        op;
    logic              issue;
    logic              md_done;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic [DATA_W-1:0] alu_res;

    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] store_q,  store_d;
    logic [RD_W-1:0]   rd_q,     rd_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [DATA_W-1:0] hi_q,     hi_d;
    logic [DATA_W-1:0] lo_q,     lo_d;

    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [4:0]        fn,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] hi,
        input logic [DATA_W-1:0] lo
    );
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic [SH_W-1:0]          sh;
        sa = a;
        sb = b;
        sh = a[SH_W-1:0];
        case (fn)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_NOR:  return ~(a | b);
            ALU_SLT:  return DATA_W'(sa < sb);
            ALU_SLTU: return DATA_W'(a < b);
            ALU_SLL:  return b << sh;
            ALU_SRL:  return b >> sh;
            ALU_SRA:  return sb >>> sh;
            ALU_MFHI: return hi;
            ALU_MFLO: return lo;
            default:  return '0;
        endcase
    endfunction

    assign op      = 5'(ALU_Control);
    assign issue   = (state_q == ST_IDLE) && in_valid && is_md_op(op);
    assign alu_res = alu_eval(op, data_1, data_2, hi_q, lo_q);

    mul_div_unit #(
        .DATA_W (DATA_W)
    ) u_md (
        .clk     (CLOCK),
        .rst     (RESET),
        .start_i (issue),
        .op_i    (md_op_e'(op[1:0])),
        .a_i     (data_1),
        .b_i     (data_2),
        .done_o  (md_done),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_BUSY;
                    stall   = 1'b1;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (md_done) begin
                    state_d = ST_DONE;
                end
            end
            // Inputs still hold the md op here; returning to IDLE without issuing
            // lets upstream advance on this edge.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (RESET) begin
            stall = 1'b0;
        end
    end

    always_comb begin
        valid_d  = 1'b0;
        result_d = '0;
        store_d  = '0;
        rd_d     = '0;
        ctrl_d   = '0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (state_q == ST_DONE) begin
            valid_d  = 1'b1;
            result_d = md_lo;
            store_d  = data_2;
            rd_d     = RD;
            ctrl_d   = Control;
            hi_d     = md_hi;
            lo_d     = md_lo;
        end else if (!stall && in_valid) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            store_d  = data_2;
            rd_d     = RD;
            ctrl_d   = Control;
        end
    end

    // EX/MEM boundary and HI/LO
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            store_q  <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            store_q  <= store_d;
            rd_q     <= rd_d;
            ctrl_q   <= ctrl_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign out_valid   = valid_q;
    assign ALU_result  = result_q;
    assign store_data  = store_q;
    assign RD_out      = rd_q;
    assign Control_out = ctrl_q;
    assign HI          = hi_q;
    assign LO          = lo_q;

endmodule
